// File: rtl/muldiv_iter_pkg.sv
// Shared RV32M multiply/divide definitions: funct3 op encodings (also used by
// decode), FSM states and operand-signedness helpers.
package muldiv_iter_pkg;

    localparam logic [2:0] MULDIV_OP_MUL    = 3'b000;
    localparam logic [2:0] MULDIV_OP_MULH   = 3'b001;
    localparam logic [2:0] MULDIV_OP_MULHSU = 3'b010;
    localparam logic [2:0] MULDIV_OP_MULHU  = 3'b011;
    localparam logic [2:0] MULDIV_OP_DIV    = 3'b100;
    localparam logic [2:0] MULDIV_OP_DIVU   = 3'b101;
    localparam logic [2:0] MULDIV_OP_REM    = 3'b110;
    localparam logic [2:0] MULDIV_OP_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // rs1 is treated as signed for everything except the unsigned forms.
    // MUL's low word is sign-agnostic, so it is handled as signed.
    function automatic logic rs1_signed(input logic [2:0] f3);
        return (f3 != MULDIV_OP_MULHU) && (f3 != MULDIV_OP_DIVU) &&
               (f3 != MULDIV_OP_REMU);
    endfunction

    // rs2 is signed only for MUL/MULH/DIV/REM (MULHSU takes rs2 unsigned).
    function automatic logic rs2_signed(input logic [2:0] f3);
        return (f3 == MULDIV_OP_MUL) || (f3 == MULDIV_OP_MULH) ||
               (f3 == MULDIV_OP_DIV) || (f3 == MULDIV_OP_REM);
    endfunction

endpackage

// File: rtl/muldiv_iter_div_core.sv
// Restoring divider datapath: one quotient bit per step on unsigned magnitudes.
// quo_next/rem_next expose the values the current step will produce so the
// controller can register the final result on the last step edge.
import muldiv_iter_pkg::*;

module muldiv_div_core #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            load,
    input  logic            step,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] quo_next,
    output logic [XLEN-1:0] rem_next
);

    logic [XLEN-1:0] rem;
    logic [XLEN-1:0] quo;
    logic [XLEN-1:0] dvsr;
    logic [XLEN:0]   shifted;
    logic [XLEN-1:0] sub;
    logic            fits;

    // Shift next dividend bit into the partial remainder; subtract when it fits.
    // When it fits the true difference is below the divisor, so the low XLEN
    // bits of the modular subtraction are exact.
    assign shifted  = {rem, quo[XLEN-1]};
    assign fits     = shifted >= {1'b0, dvsr};
    assign sub      = shifted[XLEN-1:0] - dvsr;
    assign rem_next = fits ? sub : shifted[XLEN-1:0];
    assign quo_next = {quo[XLEN-2:0], fits};

    // Quotient register doubles as the dividend shift register.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            rem  <= '0;
            quo  <= '0;
            dvsr <= '0;
        end else if (load) begin
            rem  <= '0;
            quo  <= dividend;
            dvsr <= divisor;
        end else if (step) begin
            rem  <= rem_next;
            quo  <= quo_next;
        end
    end

endmodule

// File: rtl/muldiv_iter.sv
// Iterative RV32M multiply/divide unit for the EX stage.
// Optional feature: MULDIV_FAST_MUL_EN makes all multiplies single-cycle using a
// 33x33 signed multiplier; otherwise a 32-step shift-add multiplier is used.
import muldiv_iter_pkg::*;

module muldiv_iter #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            start_i,
    input  logic [3:0]      op_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic            flush_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [1:0]        f3_q;
    logic              neg_q;
    logic              neg_r;

    logic [2:0]        f3;
    logic              is_div;
    logic              a_neg, b_neg;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic              div_zero, div_ovf, special, fast_mul, single_cycle;
    logic              accept, last;
    logic [XLEN-1:0]   special_res, quick_res, mul_result, div_result;
    logic [XLEN-1:0]   quo_next, rem_next;
    logic [2*XLEN-1:0] prod_nxt;

    assign f3     = op_i[2:0];
    assign is_div = f3[2];

    // Operand prep: magnitudes for the unsigned core, signs kept for fix-up.
    assign a_neg = rs1_signed(f3) & rs1_i[XLEN-1];
    assign b_neg = rs2_signed(f3) & rs2_i[XLEN-1];
    assign a_mag = a_neg ? -rs1_i : rs1_i;
    assign b_mag = b_neg ? -rs2_i : rs2_i;

    // Divide-by-zero and signed overflow finish without iterating.
    assign div_zero    = is_div & (rs2_i == '0);
    assign div_ovf     = is_div & ~f3[0] & (rs1_i == {1'b1, {(XLEN-1){1'b0}}}) &
                         (rs2_i == '1);
    assign special     = div_zero | div_ovf;
    assign special_res = div_zero ? (f3[1] ? rs1_i : '1) : (f3[1] ? '0 : rs1_i);

`ifdef MULDIV_FAST_MUL_EN
    logic signed [XLEN:0]     fa, fb;
    logic signed [2*XLEN-1:0] fp;

    assign fa         = {rs1_signed(f3) & rs1_i[XLEN-1], rs1_i};
    assign fb         = {rs2_signed(f3) & rs2_i[XLEN-1], rs2_i};
    assign fp         = (2*XLEN)'(fa) * (2*XLEN)'(fb);
    assign prod_nxt   = fp;
    assign mul_result = (f3[1:0] == 2'b00) ? prod_nxt[XLEN-1:0] : prod_nxt[2*XLEN-1:XLEN];
    assign fast_mul   = ~is_div;
    assign quick_res  = special ? special_res : mul_result;
`else
    logic [XLEN-1:0]   prod_hi, prod_lo, mcand;
    logic [XLEN:0]     psum;
    logic [2*XLEN-1:0] prod_fix;

    // Shift-add step: conditionally add multiplicand to the high half, shift right.
    assign psum       = {1'b0, prod_hi} + (prod_lo[0] ? {1'b0, mcand} : '0);
    assign prod_nxt   = {psum, prod_lo[XLEN-1:1]};
    assign prod_fix   = neg_q ? -prod_nxt : prod_nxt;
    assign mul_result = (f3_q == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
    assign fast_mul   = 1'b0;
    assign quick_res  = special_res;

    // Multiplier registers: load magnitudes on accept, step while in MUL.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            prod_hi <= '0;
            prod_lo <= '0;
            mcand   <= '0;
        end else if (accept & ~is_div) begin
            prod_hi <= '0;
            prod_lo <= b_mag;
            mcand   <= a_mag;
        end else if (state == ST_MUL) begin
            {prod_hi, prod_lo} <= prod_nxt;
        end
    end
`endif

    assign div_result = f3_q[1] ? (neg_r ? -rem_next : rem_next)
                                : (neg_q ? -quo_next : quo_next);

    assign single_cycle = special | fast_mul;
    // op_i[3] is always set for M ops; gating on it rejects stray starts.
    assign accept = start_i & op_i[3] & ~flush_i &
                    ((state == ST_IDLE) | (state == ST_DONE));
    assign busy_o = (state == ST_MUL) | (state == ST_DIV) | (accept & ~single_cycle);
    assign last   = (cnt == CNT_W'(XLEN-1));

    muldiv_div_core #(.XLEN(XLEN)) u_div (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .load     (accept & is_div & ~special),
        .step     (state == ST_DIV),
        .dividend (a_mag),
        .divisor  (b_mag),
        .quo_next (quo_next),
        .rem_next (rem_next)
    );

    // Control FSM with registered done pulse and result; flush beats start.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            f3_q     <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            done_o   <= 1'b0;
            result_o <= '0;
        end else begin
            done_o <= 1'b0;
            if (flush_i) begin
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE, ST_DONE: begin
                        if (accept) begin
                            f3_q  <= f3[1:0];
                            neg_q <= a_neg ^ b_neg;
                            neg_r <= a_neg;
                            cnt   <= '0;
                            if (single_cycle) begin
                                state    <= ST_DONE;
                                done_o   <= 1'b1;
                                result_o <= quick_res;
                            end else begin
                                state <= is_div ? ST_DIV : ST_MUL;
                            end
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                    ST_MUL: begin
                        cnt <= cnt + 1'b1;
                        if (last) begin
                            state    <= ST_DONE;
                            done_o   <= 1'b1;
                            result_o <= mul_result;
                        end
                    end
                    ST_DIV: begin
                        cnt <= cnt + 1'b1;
                        if (last) begin
                            state    <= ST_DONE;
                            done_o   <= 1'b1;
                            result_o <= div_result;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_muldiv_iter.sv
// Directed self-checking bench for muldiv_iter (default build).
module tb_muldiv_iter;

    logic        clk = 1'b0;
    logic        reset_i = 1'b0;
    logic        start_i = 1'b0;
    logic [3:0]  op_i = 4'h0;
    logic [31:0] rs1_i = '0;
    logic [31:0] rs2_i = '0;
    logic        flush_i = 1'b0;
    logic        busy_o, done_o;
    logic [31:0] result_o;

    int checks = 0;
    int errors = 0;

    localparam logic [3:0] OP_MUL = 4'b1000, OP_MULH = 4'b1001, OP_MULHSU = 4'b1010,
                           OP_MULHU = 4'b1011, OP_DIV = 4'b1100, OP_DIVU = 4'b1101,
                           OP_REM = 4'b1110, OP_REMU = 4'b1111;

    always #5 clk = ~clk;

    muldiv_iter dut (
        .clk_i   (clk),
        .reset_i (reset_i),
        .start_i (start_i),
        .op_i    (op_i),
        .rs1_i   (rs1_i),
        .rs2_i   (rs2_i),
        .flush_i (flush_i),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .result_o(result_o)
    );

    // Issue one op and wait (bounded) for done; lat counts edges after E0 (-1 on timeout).
    task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int lat, output logic bpre,
                         output int bcnt);
        @(negedge clk);
        op_i = op; rs1_i = a; rs2_i = b; start_i = 1'b1;
        #1 bpre = busy_o;
        @(posedge clk); #1 start_i = 1'b0;
        lat = 0; bcnt = 0;
        while (!done_o && lat < 100) begin
            if (busy_o) bcnt++;
            @(posedge clk); #1;
            lat++;
        end
        if (!done_o) lat = -1;
        res = result_o;
    endtask

    task automatic test_reset();
        #12;
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy_o); end
        checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL reset_done got %0b want 0", done_o); end
        checks++; if (result_o !== 32'h0) begin errors++; $display("FAIL reset_result got %h want 0", result_o); end
        @(negedge clk); reset_i = 1'b1;
    endtask

    task automatic test_mul();
        logic [31:0] r; int lat, bc; logic bp;
        do_op(OP_MUL, 32'd7, 32'hFFFFFFFD, r, lat, bp, bc);
        checks++; if (r !== 32'hFFFFFFEB) begin errors++; $display("FAIL mul_result got %h want ffffffeb", r); end
        checks++; if (lat !== 32) begin errors++; $display("FAIL mul_latency got %0d want 32", lat); end
        checks++; if (bp !== 1'b1) begin errors++; $display("FAIL mul_busy_start got %0b want 1", bp); end
        checks++; if (bc !== 32) begin errors++; $display("FAIL mul_busy_cycles got %0d want 32", bc); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL mul_busy_done got %0b want 0", busy_o); end
        @(posedge clk); #1;
        checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL mul_done_pulse got %0b want 0", done_o); end
        checks++; if (result_o !== 32'hFFFFFFEB) begin errors++; $display("FAIL mul_result_hold got %h want ffffffeb", result_o); end
    endtask

    task automatic test_mulh();
        logic [3:0]  ops [3] = '{OP_MULH, OP_MULHU, OP_MULHSU};
        logic [31:0] as  [3] = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] bs  [3] = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] exp [3] = '{32'h40000000, 32'hFFFFFFFE, 32'hFFFFFFFF};
        logic [31:0] r; int lat, bc; logic bp;
        for (int i = 0; i < 3; i++) begin
            do_op(ops[i], as[i], bs[i], r, lat, bp, bc);
            checks++; if (r !== exp[i]) begin errors++; $display("FAIL mulh_%0d got %h want %h", i, r, exp[i]); end
        end
    endtask

    task automatic test_div();
        logic [3:0]  ops [4] = '{OP_DIV, OP_REM, OP_DIVU, OP_REMU};
        logic [31:0] as  [4] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100};
        logic [31:0] bs  [4] = '{32'd2, 32'd2, 32'd7, 32'd7};
        logic [31:0] exp [4] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'd2};
        logic [31:0] r; int lat, bc; logic bp;
        for (int i = 0; i < 4; i++) begin
            do_op(ops[i], as[i], bs[i], r, lat, bp, bc);
            checks++; if (r !== exp[i]) begin errors++; $display("FAIL div_%0d got %h want %h", i, r, exp[i]); end
            checks++; if (lat !== 32) begin errors++; $display("FAIL div_lat_%0d got %0d want 32", i, lat); end
        end
    endtask

    task automatic test_special();
        logic [3:0]  ops [4] = '{OP_DIV, OP_REMU, OP_DIV, OP_REM};
        logic [31:0] as  [4] = '{32'd5, 32'd5, 32'h80000000, 32'h80000000};
        logic [31:0] bs  [4] = '{32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] exp [4] = '{32'hFFFFFFFF, 32'd5, 32'h80000000, 32'd0};
        logic [31:0] r; int lat, bc; logic bp;
        for (int i = 0; i < 4; i++) begin
            do_op(ops[i], as[i], bs[i], r, lat, bp, bc);
            checks++; if (r !== exp[i]) begin errors++; $display("FAIL special_%0d got %h want %h", i, r, exp[i]); end
            checks++; if (lat !== 0) begin errors++; $display("FAIL special_lat_%0d got %0d want 0", i, lat); end
            checks++; if (bp !== 1'b0 || bc !== 0) begin errors++; $display("FAIL special_busy_%0d got %0b/%0d want 0/0", i, bp, bc); end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] r; int lat, bc; logic bp;
        do_op(OP_DIVU, 32'd100, 32'd7, r, lat, bp, bc);
        op_i = OP_DIV; rs1_i = 32'd5; rs2_i = 32'd0; start_i = 1'b1;
        #1;
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL b2b_busy got %0b want 0", busy_o); end
        @(posedge clk); #1 start_i = 1'b0;
        checks++; if (done_o !== 1'b1) begin errors++; $display("FAIL b2b_done got %0b want 1", done_o); end
        checks++; if (result_o !== 32'hFFFFFFFF) begin errors++; $display("FAIL b2b_result got %h want ffffffff", result_o); end
        @(posedge clk); #1;
        checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL b2b_done_end got %0b want 0", done_o); end
    endtask

    task automatic test_ignore();
        int n;
        @(negedge clk);
        op_i = OP_MUL; rs1_i = 32'd3; rs2_i = 32'd5; start_i = 1'b1;
        @(posedge clk); #1;
        op_i = OP_DIVU; rs1_i = 32'd100; rs2_i = 32'd7;
        repeat (5) @(posedge clk);
        #1 start_i = 1'b0;
        n = 5;
        while (!done_o && n < 100) begin @(posedge clk); #1; n++; end
        checks++; if (n !== 32) begin errors++; $display("FAIL ignore_lat got %0d want 32", n); end
        checks++; if (result_o !== 32'd15) begin errors++; $display("FAIL ignore_result got %h want f", result_o); end
    endtask

    task automatic test_flush();
        logic [31:0] r; int lat, bc, dn; logic bp;
        @(negedge clk);
        op_i = OP_MUL; rs1_i = 32'h12345678; rs2_i = 32'd9; start_i = 1'b1;
        @(posedge clk); #1 start_i = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk); flush_i = 1'b1;
        @(posedge clk); #1 flush_i = 1'b0;
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL flush_busy got %0b want 0", busy_o); end
        checks++; if (result_o !== 32'd15) begin errors++; $display("FAIL flush_result got %h want f", result_o); end
        dn = 0;
        repeat (40) begin @(posedge clk); #1; if (done_o) dn++; end
        checks++; if (dn !== 0) begin errors++; $display("FAIL flush_no_done got %0d want 0", dn); end
        do_op(OP_MUL, 32'd3, 32'd4, r, lat, bp, bc);
        checks++; if (r !== 32'd12) begin errors++; $display("FAIL flush_mul got %h want c", r); end
        checks++; if (lat !== 32) begin errors++; $display("FAIL flush_mul_lat got %0d want 32", lat); end
    endtask

    task automatic test_async_reset();
        logic [31:0] r; int lat, bc, dn; logic bp;
        @(negedge clk);
        op_i = OP_DIVU; rs1_i = 32'd100; rs2_i = 32'd7; start_i = 1'b1;
        @(posedge clk); #1 start_i = 1'b0;
        repeat (5) @(posedge clk);
        #3 reset_i = 1'b0;
        #1;
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL areset_busy got %0b want 0", busy_o); end
        checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL areset_done got %0b want 0", done_o); end
        checks++; if (result_o !== 32'h0) begin errors++; $display("FAIL areset_result got %h want 0", result_o); end
        @(negedge clk); reset_i = 1'b1;
        dn = 0;
        repeat (40) begin @(posedge clk); #1; if (done_o) dn++; end
        checks++; if (dn !== 0) begin errors++; $display("FAIL areset_no_done got %0d want 0", dn); end
        do_op(OP_DIVU, 32'd100, 32'd7, r, lat, bp, bc);
        checks++; if (r !== 32'd14) begin errors++; $display("FAIL areset_recover got %h want e", r); end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_mulh();
        test_div();
        test_special();
        test_back_to_back();
        test_ignore();
        test_flush();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
